// File: rtl/alarm_sequencer.sv
// Alarm ringing controller: time/alarm match -> ring, snooze, timeout, lockout; drives LED and 1 Hz buzzer.
// Build macro ALARM_SNOOZE_EN enables snooze; when undefined, snooze acts as dismiss.
module alarm_sequencer #(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       alarm_en,
  input  logic       adjust,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [4:0] alm_hour,
  input  logic [5:0] alm_min,
  input  logic       snooze,
  input  logic       dismiss,
  output logic       ring,
  output logic       buzz,
  output logic       snoozing,
  output logic [3:0] snooze_left,
  output logic [1:0] state_dbg
);

  // Handshake: tick_1hz, snooze and dismiss are single-cycle pulses sampled on the rising clk edge.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RING    = 2'd1,
    SNOOZE  = 2'd2,
    LOCKOUT = 2'd3
  } state_e;

  if (RING_TIMEOUT_S < 1 || RING_TIMEOUT_S > 65535) begin : g_bad_ring
    $error("RING_TIMEOUT_S out of range 1..65535");
  end
  if (SNOOZE_S < 1 || SNOOZE_S > 65535) begin : g_bad_snooze
    $error("SNOOZE_S out of range 1..65535");
  end
  if (MAX_SNOOZE < 0 || MAX_SNOOZE > 15) begin : g_bad_max
    $error("MAX_SNOOZE out of range 0..15");
  end

  localparam logic [15:0] RING_T = 16'(RING_TIMEOUT_S);

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic        beep_phase_q, beep_phase_d;
  logic        match;
  logic        abort;
  logic        stop_req;

  assign match = (cur_hour == alm_hour) & (cur_min == alm_min);
  assign abort = adjust | ~alarm_en;

`ifdef ALARM_SNOOZE_EN
  localparam logic [15:0] SNZ_T   = 16'(SNOOZE_S);
  localparam logic [3:0]  MAX_SNZ = 4'(MAX_SNOOZE);

  logic [3:0] snz_used_q, snz_used_d;
  logic       snz_take;

  assign stop_req = dismiss;
  assign snz_take = snooze & (snz_used_q < MAX_SNZ);
`else
  assign stop_req = dismiss | snooze;
`endif

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    beep_phase_d = beep_phase_q;
`ifdef ALARM_SNOOZE_EN
    snz_used_d   = snz_used_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (alarm_en & ~adjust & match) begin
          state_d      = RING;
          timer_d      = RING_T;
          beep_phase_d = 1'b1;
`ifdef ALARM_SNOOZE_EN
          snz_used_d   = 4'd0;
`endif
        end
      end
      RING: begin
        if (abort | stop_req) begin
          state_d = LOCKOUT;
`ifdef ALARM_SNOOZE_EN
        end else if (snz_take) begin
          // A snooze on a tick cycle reloads the timer, so the tick never expires the ring.
          state_d    = SNOOZE;
          timer_d    = SNZ_T;
          snz_used_d = snz_used_q + 4'd1;
`endif
        end else if (tick_1hz) begin
          beep_phase_d = ~beep_phase_q;
          if (timer_q == 16'd1) state_d = LOCKOUT;
          else                  timer_d = timer_q - 16'd1;
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (abort | dismiss) begin
          state_d = LOCKOUT;
        end else if (tick_1hz) begin
          if (timer_q == 16'd1) begin
            state_d      = RING;
            timer_d      = RING_T;
            beep_phase_d = 1'b1;
          end else begin
            timer_d = timer_q - 16'd1;
          end
        end
      end
`endif
      LOCKOUT: begin
        // Held until the alarm minute has passed, so the same minute cannot retrigger.
        if (~match & ~adjust) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= 16'd0;
      beep_phase_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      beep_phase_q <= beep_phase_d;
    end
  end

  assign ring      = (state_q == RING);
  assign buzz      = ring & beep_phase_q;
  assign state_dbg = state_q;

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) snz_used_q <= 4'd0;
    else     snz_used_q <= snz_used_d;
  end

  assign snoozing    = (state_q == SNOOZE);
  assign snooze_left = MAX_SNZ - snz_used_q;
`else
  assign snoozing    = 1'b0;
  assign snooze_left = 4'd0;
`endif

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: event-level model checked every cycle, plus directed literal checks.
// Builds with or without ALARM_SNOOZE_EN.
module tb_alarm_sequencer;

  localparam int RT = 5;
  localparam int ST = 3;
  localparam int MX = 2;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif
  localparam int EXP_LEFT_RST = SNZ ? MX : 0;

  logic       clk, rst, tick_1hz, alarm_en, adjust, snooze, dismiss;
  logic [4:0] cur_hour, alm_hour;
  logic [5:0] cur_min, alm_min;
  logic       ring, buzz, snoozing;
  logic [3:0] snooze_left;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  alarm_sequencer #(.RING_TIMEOUT_S(RT), .SNOOZE_S(ST), .MAX_SNOOZE(MX)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .alarm_en(alarm_en), .adjust(adjust),
    .cur_hour(cur_hour), .cur_min(cur_min), .alm_hour(alm_hour), .alm_min(alm_min),
    .snooze(snooze), .dismiss(dismiss), .ring(ring), .buzz(buzz), .snoozing(snoozing),
    .snooze_left(snooze_left), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: an alarm event is quiet, ringing, snoozed or spent (waiting for the minute
  // to pass). Phase length is counted in ticks heard since the phase began.
  localparam int M_QUIET = 0, M_RINGING = 1, M_SNOOZED = 2, M_SPENT = 3;
  int m_mode, m_ticks, m_used;
  bit m_match, m_quit;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = M_QUIET; m_ticks = 0; m_used = 0;
    end else begin
      m_match = (cur_hour == alm_hour) && (cur_min == alm_min);
      m_quit  = adjust || !alarm_en;
      case (m_mode)
        M_QUIET:
          if (alarm_en && !adjust && m_match) begin m_mode = M_RINGING; m_ticks = 0; m_used = 0; end
        M_RINGING:
          if (m_quit || dismiss || (!SNZ && snooze)) m_mode = M_SPENT;
          else if (SNZ && snooze && m_used < MX) begin m_mode = M_SNOOZED; m_ticks = 0; m_used++; end
          else if (tick_1hz) begin
            m_ticks++;
            if (m_ticks == RT) m_mode = M_SPENT;
          end
        M_SNOOZED:
          if (m_quit || dismiss) m_mode = M_SPENT;
          else if (tick_1hz) begin
            m_ticks++;
            if (m_ticks == ST) begin m_mode = M_RINGING; m_ticks = 0; end
          end
        default:
          if (!m_match && !adjust) m_mode = M_QUIET;
      endcase
    end
  end

  // compare process
  always @(negedge clk) begin
    if (!rst && chk_on) begin
      chk("m_ring", int'(ring), int'(m_mode == M_RINGING));
      chk("m_buzz", int'(buzz), int'(m_mode == M_RINGING && (m_ticks % 2) == 0));
      chk("m_snoozing", int'(snoozing), int'(m_mode == M_SNOOZED));
      chk("m_snooze_left", int'(snooze_left), SNZ ? (MX - m_used) : 0);
    end
  end

  // driver tasks: called at posedge+2, pulses last exactly one edge
  task automatic cyc(input bit t, input bit s, input bit d);
    tick_1hz = t; snooze = s; dismiss = d;
    @(posedge clk); #2;
    tick_1hz = 1'b0; snooze = 1'b0; dismiss = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic to_idle_0731();
    cur_min = 6'd31;
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; snooze = 1'b0; dismiss = 1'b0;
    alarm_en = 1'b1; adjust = 1'b0;
    cur_hour = 5'd7; cur_min = 6'd29; alm_hour = 5'd7; alm_min = 6'd30;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ring", int'(ring), 0);
    chk("rst_buzz", int'(buzz), 0);
    chk("rst_snoozing", int'(snoozing), 0);
    chk("rst_snooze_left", int'(snooze_left), EXP_LEFT_RST);
    chk("rst_state", int'(state_dbg), 0);
    rst = 1'b0;
    chk_on = 1'b1;
    idle(3);
    chk("pre_match_ring", int'(ring), 0);

    // ring and timeout after exactly RT ticks
    cur_min = 6'd30;
    cyc(1'b0, 1'b0, 1'b0);
    chk("s1_ring", int'(ring), 1);
    chk("s1_buzz0", int'(buzz), 1);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      chk("s1_ring_t", int'(ring), 1);
      chk("s1_buzz_t", int'(buzz), (i % 2 == 0) ? 1 : 0);
      idle(2);
    end
    cyc(1'b1, 1'b0, 1'b0);
    chk("s1_timeout", int'(ring), 0);
    idle(5);
    chk("s1_no_retrig", int'(ring), 0);
    to_idle_0731();
    chk("s1_idle_0731", int'(state_dbg), 0);

    // snooze and dismiss together: dismiss wins
    cur_min = 6'd30;
    cyc(1'b0, 1'b0, 1'b0);
    chk("s3_ring", int'(ring), 1);
    cyc(1'b0, 1'b1, 1'b1);
    chk("s3_ring_off", int'(ring), 0);
    chk("s3_snoozing", int'(snoozing), 0);
    idle(4);
    chk("s3_no_retrig", int'(ring), 0);
    to_idle_0731();

    // adjust aborts, no ring while adjusting or disarmed
    cur_min = 6'd30;
    cyc(1'b0, 1'b0, 1'b0);
    chk("s4_ring", int'(ring), 1);
    adjust = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("s4_adjust_off", int'(ring), 0);
    adjust = 1'b0;
    idle(3);
    chk("s4_no_ring_0730", int'(ring), 0);
    to_idle_0731();
    chk("s4_idle", int'(state_dbg), 0);
    alarm_en = 1'b0;
    cur_min = 6'd30;
    idle(3);
    chk("s4_disarmed", int'(ring), 0);
    to_idle_0731();
    alarm_en = 1'b1;

    // disarm while ringing
    cur_min = 6'd30;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    alarm_en = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    chk("s7_disarm_off", int'(ring), 0);
    alarm_en = 1'b1;
    idle(2);
    chk("s7_lockout", int'(ring), 0);
    to_idle_0731();

`ifdef ALARM_SNOOZE_EN
    // snooze sequence up to the snooze limit
    cur_min = 6'd30;
    cyc(1'b0, 1'b0, 1'b0);
    chk("s2_left0", int'(snooze_left), 2);
    cyc(1'b0, 1'b1, 1'b0);
    chk("s2_snoozing", int'(snoozing), 1);
    chk("s2_left1", int'(snooze_left), 1);
    chk("s2_ring_off", int'(ring), 0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("s2_still_snz", int'(snoozing), 1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("s2_rering", int'(ring), 1);
    chk("s2_rering_buzz", int'(buzz), 1);
    cyc(1'b1, 1'b1, 1'b0);
    chk("s2_snz_tick", int'(snoozing), 1);
    chk("s2_left2", int'(snooze_left), 0);
    idle(1);
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    chk("s2_rering2", int'(ring), 1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("s2_ignored", int'(ring), 1);
    chk("s2_ignored_snz", int'(snoozing), 0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("s2_dismiss", int'(ring), 0);
    to_idle_0731();

    // alarm time edited during snooze does not disturb the countdown
    cur_min = 6'd30;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    alm_min = 6'd45;
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    chk("s8_edit_ring", int'(ring), 1);
    alm_min = 6'd30;
    cyc(1'b0, 1'b0, 1'b1);
    to_idle_0731();
`else
    // snooze acts as dismiss
    cur_min = 6'd30;
    cyc(1'b0, 1'b0, 1'b0);
    chk("s6_ring", int'(ring), 1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("s6_ring_off", int'(ring), 0);
    chk("s6_snoozing", int'(snoozing), 0);
    chk("s6_left", int'(snooze_left), 0);
    idle(2);
    chk("s6_no_retrig", int'(ring), 0);
    to_idle_0731();
`endif

    // asynchronous reset mid-event
    cur_min = 6'd30;
    cyc(1'b0, 1'b0, 1'b0);
`ifdef ALARM_SNOOZE_EN
    cyc(1'b0, 1'b1, 1'b0);
    chk("s5_in_snooze", int'(snoozing), 1);
`else
    chk("s5_in_ring", int'(ring), 1);
`endif
    rst = 1'b1;
    #1;
    chk("s5_rst_ring", int'(ring), 0);
    chk("s5_rst_buzz", int'(buzz), 0);
    chk("s5_rst_snoozing", int'(snoozing), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    chk("s5_rering", int'(ring), 1);
    chk("s5_rering_buzz", int'(buzz), 1);
    cyc(1'b0, 1'b0, 1'b1);
    to_idle_0731();
    idle(2);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
